// File: rtl/negacyclic_mac_accum_pkg.sv
// Shared definitions for the negacyclic polynomial MAC datapath.
package negacyclic_mac_accum_pkg;

    // Default widths, shared with the fixed-point multiplier.
    localparam int DATA_WIDTH_DEFAULT = 32;
    localparam int N_WIDTH_DEFAULT    = 8;

    // Multiplier latency in cycles; the tag pipeline depth must match it.
    localparam int MUL_LATENCY = 1;

    // Group accumulation state.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Per-term control tag travelling alongside the multiplier operands.
    typedef struct packed {
        logic valid;
        logic neg;
        logic last;
    } tag_t;

endpackage

// File: rtl/negacyclic_mac_accum_tag_delay.sv
// Delays the per-term control tag by the multiplier latency so that it
// arrives together with the matching product.
module mac_tag_delay
    import negacyclic_mac_accum_pkg::*;
#(
    parameter int DEPTH = MUL_LATENCY
) (
    input  logic clk,
    input  logic rst,
    input  tag_t din,
    output tag_t dout
);

    tag_t pipe_r [DEPTH];

    // Shift register of tags; reset discards any terms in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe_r[i] <= '{valid: 1'b0, neg: 1'b0, last: 1'b0};
            end
        end else begin
            pipe_r[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                pipe_r[i] <= pipe_r[i-1];
            end
        end
    end

    assign dout = pipe_r[DEPTH-1];

endmodule

// File: rtl/negacyclic_mac_accum.sv
// Accumulates a group of multiplier products into one coefficient modulo
// 2^DATA_WIDTH, negating terms that wrapped around X^N = -1, and presents
// the finished coefficient on a valid/ready output.
module negacyclic_mac_accum
    import negacyclic_mac_accum_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
    parameter int n_WIDTH    = N_WIDTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_valid,
    input  logic                  issue_neg,
    input  logic                  issue_last,
    output logic                  issue_ready,
    input  logic [DATA_WIDTH-1:0] prod,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [n_WIDTH-1:0]    out_terms,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  err
);

    localparam logic [n_WIDTH-1:0]    CNT_MAX = {n_WIDTH{1'b1}};
    localparam logic [n_WIDTH-1:0]    CNT_ONE = {{(n_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [DATA_WIDTH-1:0] ZERO_W  = {DATA_WIDTH{1'b0}};

    // Two's-complement conditional negation; the most negative value maps
    // to itself, which is the intended torus behaviour.
    function automatic logic [DATA_WIDTH-1:0] cond_negate(
        input logic [DATA_WIDTH-1:0] value,
        input logic                  neg
    );
        logic [DATA_WIDTH-1:0] res;
        if (neg) begin
            res = ZERO_W - value;
        end else begin
            res = value;
        end
        return res;
    endfunction

    state_t                state_r;
    state_t                state_next_s;
    logic [DATA_WIDTH-1:0] acc_r;
    logic [n_WIDTH-1:0]    cnt_r;
    logic [DATA_WIDTH-1:0] out_data_r;
    logic [n_WIDTH-1:0]    out_terms_r;
    logic                  out_valid_r;
    logic                  err_r;

    tag_t                  issue_tag_s;
    tag_t                  d1_tag_s;
    logic                  issue_fire_s;
    logic                  accept_s;
    logic                  drop_s;
    logic [DATA_WIDTH-1:0] term_s;
    logic [DATA_WIDTH-1:0] acc_base_s;
    logic [DATA_WIDTH-1:0] acc_next_s;
    logic [n_WIDTH-1:0]    cnt_next_s;
    logic                  cnt_ovf_s;

    // Never let a last term be in flight while the output register is full.
    assign issue_ready  = !out_valid_r && !(d1_tag_s.valid && d1_tag_s.last);
    assign issue_fire_s = issue_valid && issue_ready;

    assign issue_tag_s = '{valid: issue_fire_s, neg: issue_neg, last: issue_last};

    mac_tag_delay #(
        .DEPTH (MUL_LATENCY)
    ) u_tag_delay (
        .clk  (clk),
        .rst  (rst),
        .din  (issue_tag_s),
        .dout (d1_tag_s)
    );

    // A product arriving while a result waits is a protocol violation.
    assign accept_s = d1_tag_s.valid && (state_r != DONE);
    assign drop_s   = d1_tag_s.valid && (state_r == DONE);

    // Signed term, accumulator update and term counter for the arriving product.
    always_comb begin
        term_s     = cond_negate(prod, d1_tag_s.neg);
        acc_base_s = ZERO_W;
        cnt_next_s = CNT_ONE;
        cnt_ovf_s  = 1'b0;
        if (state_r == IDLE) begin
            acc_base_s = ZERO_W;
            cnt_next_s = CNT_ONE;
        end else if (cnt_r == CNT_MAX) begin
            acc_base_s = acc_r;
            cnt_next_s = CNT_MAX;
            cnt_ovf_s  = 1'b1;
        end else begin
            acc_base_s = acc_r;
            cnt_next_s = cnt_r + CNT_ONE;
        end
        acc_next_s = acc_base_s + term_s;
    end

    // Next-state logic for group open/close and result hand-off.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (d1_tag_s.valid && d1_tag_s.last) begin
                    state_next_s = DONE;
                end else if (d1_tag_s.valid) begin
                    state_next_s = ACCUM;
                end else begin
                    state_next_s = IDLE;
                end
            end
            ACCUM: begin
                if (d1_tag_s.valid && d1_tag_s.last) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = ACCUM;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DONE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State, accumulator, result register and sticky error.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            acc_r       <= ZERO_W;
            cnt_r       <= {n_WIDTH{1'b0}};
            out_data_r  <= ZERO_W;
            out_terms_r <= {n_WIDTH{1'b0}};
            out_valid_r <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            state_r <= state_next_s;
            if (accept_s) begin
                acc_r <= acc_next_s;
                cnt_r <= cnt_next_s;
            end
            if (accept_s && d1_tag_s.last) begin
                out_data_r  <= acc_next_s;
                out_terms_r <= cnt_next_s;
                out_valid_r <= 1'b1;
            end else if (out_valid_r && out_ready) begin
                out_valid_r <= 1'b0;
            end
            if (drop_s || (accept_s && cnt_ovf_s)) begin
                err_r <= 1'b1;
            end
        end
    end

    assign out_data  = out_data_r;
    assign out_terms = out_terms_r;
    assign out_valid = out_valid_r;
    assign err       = err_r;

endmodule
